// File: rtl/dm_bus.sv
// dm_bus: multi-cycle data memory for the MIPS core.
//
// It supports byte, halfword and word loads and stores with sign or zero
// extension. Requests use a REQ/READY handshake and completion is signalled
// by a one-cycle VALID pulse. Each access takes WAIT extra cycles.
// Misaligned accesses and the reserved SIZE code are reported on ERR.
// When ZERO_INIT=1, the whole memory is swept to zero after reset.
//
// Ports
//   CLK    in   rising-edge clock
//   RST    in   asynchronous active-low reset
//   REQ    in   access request, sampled only while READY=1
//   WE     in   1 = store, 0 = load
//   SIZE   in   00 byte, 01 halfword, 10 word, 11 reserved (error)
//   SEXT   in   loads: 1 sign-extend, 0 zero-extend
//   ADDR   in   byte address (wraps modulo 4*DEPTH)
//   WDATA  in   right-aligned store data
//   READY  out  block can accept a request this cycle
//   VALID  out  one-cycle completion pulse
//   RDATA  out  load result; 0 after stores and errors
//   ERR    out  misaligned/reserved access, qualified by VALID
module dm_bus #(
  parameter int DEPTH     = 64,
  parameter int WAIT      = 0,
  parameter bit ZERO_INIT = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        WE,
  input  logic [1:0]  SIZE,
  input  logic        SEXT,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic        READY,
  output logic        VALID,
  output logic [31:0] RDATA,
  output logic        ERR
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ACCESS} state_t;

  state_t        state_reg, state_next;
  logic          live_reg;      // low until the first edge after reset release
  logic [AW-1:0] sweep_reg;
  logic [3:0]    wait_reg;
  logic          we_reg, sext_reg;
  logic [1:0]    size_reg;
  logic [AW+1:0] addr_reg;
  logic [31:0]   wdata_reg;
  logic          valid_reg, err_reg;
  logic [31:0]   rdata_reg;

  logic          ready, accept, done, init_we, mis_err;
  logic [3:0]    lane_sel, lane_we;
  logic [AW-1:0] wr_idx, rd_idx;
  logic [31:0]   rd_word, load_val, byte_sh;

  // Address bits above the memory are deliberately ignored (wrap-around).
  logic addr_unused;
  assign addr_unused = ^ADDR[31:AW+2];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_reg <= ZERO_INIT ? ST_INIT : ST_IDLE;
    else      state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_INIT:   if (sweep_reg == AW'(DEPTH - 1)) state_next = ST_IDLE;
      ST_IDLE:   if (REQ && live_reg) state_next = ST_ACCESS;
      ST_ACCESS: if (wait_reg == 4'd0) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ready   = 1'b0;
    done    = 1'b0;
    init_we = 1'b0;
    case (state_reg)
      ST_INIT:   init_we = 1'b1;
      ST_IDLE:   ready   = live_reg;
      ST_ACCESS: done    = (wait_reg == 4'd0);
      default:   ready   = 1'b0;
    endcase
  end

  assign accept = ready & REQ;

  // Alignment check on the latched request.
  always_comb begin
    mis_err = 1'b0;
    case (size_reg)
      2'd1:    mis_err = addr_reg[0];
      2'd2:    mis_err = (addr_reg[1:0] != 2'd0);
      2'd3:    mis_err = 1'b1;
      default: mis_err = 1'b0;
    endcase
  end

  // Byte lanes touched by a store (little-endian).
  always_comb begin
    lane_sel = 4'b0000;
    case (size_reg)
      2'd0:    lane_sel[addr_reg[1:0]] = 1'b1;
      2'd1:    lane_sel = addr_reg[1] ? 4'b1100 : 4'b0011;
      2'd2:    lane_sel = 4'b1111;
      default: lane_sel = 4'b0000;
    endcase
  end

  assign wr_idx = init_we ? sweep_reg : addr_reg[AW+1:2];
  // In IDLE the read is launched from the live address, so the word is ready
  // at the completion edge even when WAIT=0. Later it tracks the latched address.
  assign rd_idx = (state_reg == ST_IDLE) ? ADDR[AW+1:2] : addr_reg[AW+1:2];

  // One byte-wide RAM per lane. Each RAM has a byte write enable and a registered read.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_byte_reg;
      logic [7:0] wbyte;

      always_comb begin
        wbyte = WDATA[7:0] & 8'h00;
        if (init_we)                wbyte = 8'h00;
        else if (size_reg == 2'd2)  wbyte = wdata_reg[8*gi +: 8];
        else if (size_reg == 2'd1)  wbyte = wdata_reg[8*(gi%2) +: 8];
        else                        wbyte = wdata_reg[7:0];
      end

      assign lane_we[gi] = init_we | (done & we_reg & ~mis_err & lane_sel[gi]);

      always_ff @(posedge CLK) begin
        if (lane_we[gi]) mem[wr_idx] <= wbyte;
        rd_byte_reg <= mem[rd_idx];
      end

      assign rd_word[8*gi +: 8] = rd_byte_reg;
    end
  endgenerate

  // Load formatting: extract the addressed lanes and extend them.
  assign byte_sh = rd_word >> {addr_reg[1:0], 3'b000};

  always_comb begin
    load_val = 32'd0;
    case (size_reg)
      2'd0: load_val = sext_reg ? {{24{byte_sh[7]}}, byte_sh[7:0]}
                                : {24'd0, byte_sh[7:0]};
      2'd1: load_val = addr_reg[1]
                       ? (sext_reg ? {{16{rd_word[31]}}, rd_word[31:16]} : {16'd0, rd_word[31:16]})
                       : (sext_reg ? {{16{rd_word[15]}}, rd_word[15:0]}  : {16'd0, rd_word[15:0]});
      2'd2: load_val = rd_word;
      default: load_val = 32'd0;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      live_reg  <= 1'b0;
      sweep_reg <= '0;
      wait_reg  <= 4'd0;
      we_reg    <= 1'b0;
      sext_reg  <= 1'b0;
      size_reg  <= 2'd0;
      addr_reg  <= '0;
      wdata_reg <= 32'd0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      rdata_reg <= 32'd0;
    end else begin
      live_reg  <= 1'b1;
      valid_reg <= done;
      if (init_we) sweep_reg <= sweep_reg + AW'(1);
      if (accept) begin
        we_reg    <= WE;
        sext_reg  <= SEXT;
        size_reg  <= SIZE;
        addr_reg  <= ADDR[AW+1:0];
        wdata_reg <= WDATA;
        wait_reg  <= 4'(WAIT);
      end else if (state_reg == ST_ACCESS && wait_reg != 4'd0) begin
        wait_reg <= wait_reg - 4'd1;
      end
      if (done) begin
        err_reg   <= mis_err;
        rdata_reg <= (we_reg || mis_err) ? 32'd0 : load_val;
      end
    end
  end

  assign READY = ready;
  assign VALID = valid_reg;
  assign RDATA = rdata_reg;
  assign ERR   = err_reg;

endmodule

// File: tb/tb_dm_bus.sv
module tb_dm_bus;

  localparam int DEPTH = 64;
  localparam int WAIT  = 3;

  logic        CLK, RST, REQ, WE, SEXT;
  logic [1:0]  SIZE;
  logic [31:0] ADDR, WDATA;
  logic        READY, VALID, ERR;
  logic [31:0] RDATA;

  dm_bus #(.DEPTH(DEPTH), .WAIT(WAIT), .ZERO_INIT(1'b1)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .SIZE(SIZE), .SEXT(SEXT),
    .ADDR(ADDR), .WDATA(WDATA), .READY(READY), .VALID(VALID),
    .RDATA(RDATA), .ERR(ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          edge_no;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem_m [DEPTH*4];
  int         checks = 0;
  int         errors = 0;
  bit         prev_v = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte-addressed little-endian memory of 4*DEPTH bytes.
  function automatic void model(input bit we, input bit [1:0] sz, input bit sx,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err);
    int b;
    int nb;
    logic [31:0] v;
    b   = int'(a % (DEPTH*4));
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    rd  = 32'd0;
    if (err) return;
    nb = 1 << sz;
    if (we) begin
      for (int i = 0; i < nb; i++) mem_m[b+i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_m[b+i];
      if (sz == 2'd0)      rd = sx ? {{24{v[7]}}, v[7:0]}   : {24'd0, v[7:0]};
      else if (sz == 2'd1) rd = sx ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
      else                 rd = v;
    end
  endfunction

  // Issue one access; called just after a falling edge. hold keeps REQ high
  // (with scrambled fields) for that many edges after the accept.
  task automatic op(input bit we, input bit [1:0] sz, input bit sx,
                    input logic [31:0] a, input logic [31:0] wd, input int hold);
    exp_t e;
    int   n;
    n = 0;
    while (!READY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!READY) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: READY still %b after %0d cycles, required 1", READY, n);
      return;
    end
    REQ = 1'b1; WE = we; SIZE = sz; SEXT = sx; ADDR = a; WDATA = wd;
    model(we, sz, sx, a, wd, e.rdata, e.err);
    e.edge_no = cyc + 1 + WAIT + 1;
    exp_q.push_back(e);
    $display("op we=%0b size=%0d sext=%0b addr=%h wdata=%h -> expect rdata=%h err=%0b",
             we, sz, sx, a, wd, e.rdata, e.err);
    @(posedge CLK);
    @(negedge CLK);
    for (int i = 0; i < hold; i++) begin
      WE = 1'($urandom); SIZE = 2'($urandom); SEXT = 1'($urandom);
      ADDR = $urandom; WDATA = $urandom;
      @(negedge CLK);
    end
    REQ = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, READY}, 32'd0);
    chk({tag, "_valid"}, {31'd0, VALID}, 32'd0);
    chk({tag, "_err"},   {31'd0, ERR},   32'd0);
    chk({tag, "_rdata"}, RDATA, 32'd0);
  endtask

  // Release reset at a falling edge and measure the sweep length in edges.
  task automatic release_and_sweep();
    int n;
    RST = 1'b1;
    for (int i = 0; i < DEPTH*4; i++) mem_m[i] = 8'h00;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!READY && n < 200);
    chk("sweep_len", n, DEPTH);
  endtask

  // Monitor: pops the scoreboard on every VALID.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST) begin
        if (VALID) begin
          chk("valid_not_back_to_back", {31'd0, prev_v}, 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_valid: VALID=1 at cycle %0d with no access outstanding", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("rdata", RDATA, e.rdata);
            chk("err", {31'd0, ERR}, {31'd0, e.err});
            chk("valid_edge", cyc, e.edge_no);
            chk("ready_with_valid", {31'd0, READY}, 32'd1);
          end
        end
        prev_v = VALID;
      end else begin
        prev_v = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] a;
    bit   [1:0]  sz;
    RST = 1'b0; REQ = 1'b0; WE = 1'b0; SIZE = 2'd0; SEXT = 1'b0;
    ADDR = 32'd0; WDATA = 32'd0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset0");
    release_and_sweep();

    // Directed sequence.
    op(1'b0, 2'd2, 1'b0, 32'h0000_00FC, 32'h0, 0);
    op(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 0);
    op(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 0);
    op(1'b1, 2'd2, 1'b0, 32'h0000_0020, 32'h11223344, 0);
    op(1'b1, 2'd0, 1'b0, 32'h0000_0022, 32'h000000AA, 1);
    op(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0, 0);
    op(1'b0, 2'd0, 1'b1, 32'h0000_0022, 32'h0, 0);
    op(1'b0, 2'd1, 1'b0, 32'h0000_0022, 32'h0, 0);
    op(1'b1, 2'd1, 1'b0, 32'h0000_0021, 32'h0000BBBB, 0);
    op(1'b0, 2'd2, 1'b0, 32'h0000_0022, 32'h0, 0);
    op(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0, 0);
    op(1'b0, 2'd3, 1'b0, 32'h0000_0020, 32'h0, 0);
    op(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'h00000005, WAIT + 1);
    op(1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0, WAIT + 1);

    // Randomised traffic around a small window so stores and loads collide.
    for (int k = 0; k < 150; k++) begin
      a = $urandom;
      a[7:5] = 3'($urandom_range(0, 1));
      sz = 2'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'd0;
      end
      op(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, WAIT + 1));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    // Load a non-zero value so the reset clear of RDATA is visible.
    op(1'b1, 2'd2, 1'b0, 32'h0000_0030, 32'hCAFEF00D, 0);
    op(1'b0, 2'd2, 1'b0, 32'h0000_0030, 32'h0, 0);
    repeat (WAIT + 3) @(negedge CLK);

    // Reset during an in-flight store: the access is dropped with no VALID.
    op(1'b1, 2'd2, 1'b0, 32'h0000_0044, 32'h12345678, 0);
    @(negedge CLK);
    RST = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("reset_mid");
    repeat (WAIT + 4) @(negedge CLK);
    check_reset_outputs("reset_hold");
    release_and_sweep();
    op(1'b0, 2'd2, 1'b0, 32'h0000_0044, 32'h0, 0);
    op(1'b0, 2'd2, 1'b0, 32'h0000_0030, 32'h0, 0);

    repeat (WAIT + 4) @(negedge CLK);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global safety bound so the run always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: simulation bound reached at cycle %0d, required completion earlier", cyc);
    $fatal(1);
  end

endmodule
